gpio_apb_arb: RTL and testbench

Two-port APB arbiter that shares the single gpio_top APB slave (7-bit address window, no pready) between two upstream requesters: port 0 for the CPU bus and port 1 for the pattern/DMA sequencer.
It serialises transactions and regenerates a legal downstream setup/access sequence. It returns registered read data and pready to the granted requester and stalls the other one.
It sits between the APB bridge and the gpio wrapper, sharing the wrapper's pclk/presetn.

---
 rtl/gpio_arb_pkg.sv | 16 +
 rtl/gpio_arb_rr2.sv | 23 ++
 rtl/gpio_apb_arb.sv | 117 +++++++++++
 tb/tb_gpio_apb_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the two-port APB arbiter in front of the gpio slave:
// FSM state encoding, one-hot grant codes and the default downstream address width.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;
    localparam int         ARB_ADDR_W = 7;

endpackage

// File: rtl/gpio_arb_rr2.sv
// Combinational 2-way picker: round-robin on ties, or port 0 always wins
// ties when fixed_prio is set. Produces a one-hot grant, 00 when nothing requests.
module gpio_arb_rr2
    import gpio_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = GRANT_P0;
            2'b10: gnt = GRANT_P1;
            // last_grant is the index of the previous winner; the other port goes next
            2'b11: gnt = (fixed_prio || last_grant) ? GRANT_P0 : GRANT_P1;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/gpio_apb_arb.sv
// Two-port APB arbiter sharing the gpio slave: serialises requests, regenerates
// a clean SETUP/ACCESS sequence downstream and returns registered prdata/pready.
module gpio_apb_arb
    import gpio_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
)
(
    input  logic              pclk,
    input  logic              presetn,
    input  logic              s0_psel,
    input  logic              s0_penable,
    input  logic              s0_pwrite,
    input  logic [31:0]       s0_paddr,
    input  logic [DATA_W-1:0] s0_pwdata,
    output logic [DATA_W-1:0] s0_prdata,
    output logic              s0_pready,
    input  logic              s1_psel,
    input  logic              s1_penable,
    input  logic              s1_pwrite,
    input  logic [31:0]       s1_paddr,
    input  logic [DATA_W-1:0] s1_pwdata,
    output logic [DATA_W-1:0] s1_prdata,
    output logic              s1_pready,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [ADDR_W-1:0] m_paddr,
    output logic [DATA_W-1:0] m_pwdata,
    input  logic [DATA_W-1:0] m_prdata,
    output logic [1:0]        grant
);

    arb_state_t state;
    logic       last_grant;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       unused_inputs;

    // penable and the upper address bits play no part in arbitration or forwarding
    assign unused_inputs = ^{s0_penable, s1_penable, s0_paddr[31:ADDR_W], s1_paddr[31:ADDR_W]};

    // pready high marks the requester's completion cycle, so it is not a new request
    assign req = {s1_psel & ~s1_pready, s0_psel & ~s0_pready};

    gpio_arb_rr2 u_pick (
        .req        (req),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt        (gnt)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            m_psel     <= 1'b0;
            m_penable  <= 1'b0;
            m_pwrite   <= 1'b0;
            m_paddr    <= '0;
            m_pwdata   <= '0;
            s0_prdata  <= '0;
            s1_prdata  <= '0;
            s0_pready  <= 1'b0;
            s1_pready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        m_psel     <= 1'b1;
                        m_penable  <= 1'b0;
                        grant      <= gnt;
                        last_grant <= gnt[1];
                        if (gnt[1]) begin
                            m_paddr  <= s1_paddr[ADDR_W-1:0];
                            m_pwdata <= s1_pwdata;
                            m_pwrite <= s1_pwrite;
                        end else begin
                            m_paddr  <= s0_paddr[ADDR_W-1:0];
                            m_pwdata <= s0_pwdata;
                            m_pwrite <= s0_pwrite;
                        end
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    m_penable <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // slave has no wait states: read data is valid in this cycle
                    if (grant[1]) begin
                        if (!m_pwrite) s1_prdata <= m_prdata;
                        s1_pready <= 1'b1;
                    end else begin
                        if (!m_pwrite) s0_prdata <= m_prdata;
                        s0_pready <= 1'b1;
                    end
                    m_psel    <= 1'b0;
                    m_penable <= 1'b0;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    s0_pready <= 1'b0;
                    s1_pready <= 1'b0;
                    grant     <= 2'b00;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_apb_arb.sv
// Bench for gpio_apb_arb: a round-robin and a fixed-priority instance driven by
// random APB requesters and compared every cycle with a transaction-timing model.
module tb_gpio_apb_arb;

    logic        clk;
    logic        presetn;
    logic        s_psel    [2][2];
    logic        s_penable [2][2];
    logic        s_pwrite  [2][2];
    logic [31:0] s_paddr   [2][2];
    logic [31:0] s_pwdata  [2][2];
    logic [31:0] s_prdata  [2][2];
    logic        s_pready  [2][2];
    logic        m_psel    [2];
    logic        m_penable [2];
    logic        m_pwrite  [2];
    logic [6:0]  m_paddr   [2];
    logic [31:0] m_pwdata  [2];
    logic [31:0] m_prdata  [2];
    logic [1:0]  grant     [2];

    int total;
    int bad;

    // instance 0: round-robin, instance 1: port 0 wins ties
    for (genvar g = 0; g < 2; g++) begin : g_dut
        gpio_apb_arb #(.ADDR_W(7), .DATA_W(32), .FIXED_PRIO(g)) u_dut (
            .pclk       (clk),
            .presetn    (presetn),
            .s0_psel    (s_psel[g][0]),
            .s0_penable (s_penable[g][0]),
            .s0_pwrite  (s_pwrite[g][0]),
            .s0_paddr   (s_paddr[g][0]),
            .s0_pwdata  (s_pwdata[g][0]),
            .s0_prdata  (s_prdata[g][0]),
            .s0_pready  (s_pready[g][0]),
            .s1_psel    (s_psel[g][1]),
            .s1_penable (s_penable[g][1]),
            .s1_pwrite  (s_pwrite[g][1]),
            .s1_paddr   (s_paddr[g][1]),
            .s1_pwdata  (s_pwdata[g][1]),
            .s1_prdata  (s_prdata[g][1]),
            .s1_pready  (s_pready[g][1]),
            .m_psel     (m_psel[g]),
            .m_penable  (m_penable[g]),
            .m_pwrite   (m_pwrite[g]),
            .m_paddr    (m_paddr[g]),
            .m_pwdata   (m_pwdata[g]),
            .m_prdata   (m_prdata[g]),
            .grant      (grant[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: a transaction sampled in idle cycle t0 shows setup at
    // t0+1, access at t0+2, pready at t0+3, and the arbiter is free from t0+4
    int unsigned cyc;
    bit          has_txn [2];
    int unsigned t0      [2];
    int          own     [2];
    int          last    [2];
    logic [6:0]  x_addr  [2];
    logic [31:0] x_wdata [2];
    logic        x_wr    [2];
    logic [31:0] x_rdata [2][2];
    logic        x_psel  [2];
    logic        x_pen   [2];
    logic        x_rdy   [2][2];
    logic [1:0]  x_grant [2];
    logic        rdy_seen [2][2];
    bit          rand_rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            has_txn[i] = 1'b0; t0[i] = 0; own[i] = 0; last[i] = 1;
            x_addr[i] = '0; x_wdata[i] = '0; x_wr[i] = 1'b0;
            x_psel[i] = 1'b0; x_pen[i] = 1'b0; x_grant[i] = 2'b00;
            for (int n = 0; n < 2; n++) begin
                x_rdata[i][n] = '0;
                x_rdy[i][n]   = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        int unsigned k;
        bit p0, p1;
        int w;
        k = cyc;
        cyc++;
        if (!presetn) begin
            reset_model();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (has_txn[i] && k == t0[i] + 2 && !x_wr[i])
                    x_rdata[i][own[i]] = m_prdata[i];
                if (!has_txn[i] || k >= t0[i] + 4) begin
                    p0 = s_psel[i][0] && !x_rdy[i][0];
                    p1 = s_psel[i][1] && !x_rdy[i][1];
                    if (p0 || p1) begin
                        if (p0 && p1) w = (i == 1) ? 0 : 1 - last[i];
                        else          w = p0 ? 0 : 1;
                        has_txn[i] = 1'b1;
                        t0[i]      = k;
                        own[i]     = w;
                        last[i]    = w;
                        x_addr[i]  = s_paddr[i][w][6:0];
                        x_wdata[i] = s_pwdata[i][w];
                        x_wr[i]    = s_pwrite[i][w];
                    end
                end
                x_psel[i]   = has_txn[i] && (cyc == t0[i] + 1 || cyc == t0[i] + 2);
                x_pen[i]    = has_txn[i] && (cyc == t0[i] + 2);
                x_rdy[i][0] = has_txn[i] && (cyc == t0[i] + 3) && own[i] == 0;
                x_rdy[i][1] = has_txn[i] && (cyc == t0[i] + 3) && own[i] == 1;
                x_grant[i]  = (has_txn[i] && cyc >= t0[i] + 1 && cyc <= t0[i] + 3)
                              ? ((own[i] == 1) ? 2'b10 : 2'b01) : 2'b00;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("u%0d_m_psel", i),    32'(m_psel[i]),      32'(x_psel[i]));
            check_val($sformatf("u%0d_m_penable", i), 32'(m_penable[i]),   32'(x_pen[i]));
            check_val($sformatf("u%0d_grant", i),     32'(grant[i]),       32'(x_grant[i]));
            check_val($sformatf("u%0d_m_paddr", i),   32'(m_paddr[i]),     32'(x_addr[i]));
            check_val($sformatf("u%0d_m_pwdata", i),  m_pwdata[i],         x_wdata[i]);
            check_val($sformatf("u%0d_m_pwrite", i),  32'(m_pwrite[i]),    32'(x_wr[i]));
            for (int n = 0; n < 2; n++) begin
                check_val($sformatf("u%0d_s%0d_pready", i, n), 32'(s_pready[i][n]), 32'(x_rdy[i][n]));
                check_val($sformatf("u%0d_s%0d_prdata", i, n), s_prdata[i][n], x_rdata[i][n]);
                rdy_seen[i][n] = s_pready[i][n];
            end
        end
    endtask

    // each requester holds its transfer until it sees pready, then may start another
    task automatic drive_masters(input int prob);
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (s_psel[i][n]) begin
                    if (rdy_seen[i][n]) begin
                        s_psel[i][n]    = 1'b0;
                        s_penable[i][n] = 1'b0;
                    end else begin
                        s_penable[i][n] = 1'b1;
                    end
                end
                if (!s_psel[i][n] && int'($urandom_range(99)) < prob) begin
                    s_psel[i][n]    = 1'b1;
                    s_penable[i][n] = 1'b0;
                    s_paddr[i][n]   = $urandom;
                    s_pwdata[i][n]  = $urandom;
                    s_pwrite[i][n]  = 1'($urandom_range(1));
                end
            end
        end
    endtask

    task automatic tick(input int prob);
        @(posedge clk);
        model_step();
        #1;
        drive_masters(prob);
        if (rand_rdata) begin
            m_prdata[0] = $urandom;
            m_prdata[1] = $urandom;
        end
        @(negedge clk);
        check_outputs();
    endtask

    int unsigned base;
    bit found;

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rand_rdata = 1'b0;
        presetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_prdata[i] = '0;
            for (int n = 0; n < 2; n++) begin
                s_psel[i][n] = 1'b0; s_penable[i][n] = 1'b0; s_pwrite[i][n] = 1'b0;
                s_paddr[i][n] = '0;  s_pwdata[i][n] = '0;    rdy_seen[i][n] = 1'b0;
            end
        end
        reset_model();

        repeat (3) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
        end
        check_val("rst_grant", 32'(grant[0]), 32'd0);
        check_val("rst_m_psel", 32'(m_psel[0]), 32'd0);

        // both ports request together right after reset: s0 write, s1 read
        @(posedge clk);
        model_step();
        #1;
        presetn = 1'b1;
        base = cyc;
        for (int i = 0; i < 2; i++) begin
            s_psel[i][0] = 1'b1; s_pwrite[i][0] = 1'b1;
            s_paddr[i][0] = 32'hFFFF_FF84; s_pwdata[i][0] = 32'h0000_00FF;
            s_psel[i][1] = 1'b1; s_pwrite[i][1] = 1'b0;
            s_paddr[i][1] = 32'h0000_0050; s_pwdata[i][1] = 32'h1111_2222;
            m_prdata[i] = 32'hA5A5_1234;
        end
        @(negedge clk);
        check_outputs();
        for (int t = 1; t <= 8; t++) begin
            tick(0);
            for (int i = 0; i < 2; i++) begin
                case (cyc - base)
                    1: begin
                        check_val("d_setup_psel", 32'(m_psel[i]), 32'd1);
                        check_val("d_setup_paddr", 32'(m_paddr[i]), 32'h04);
                        check_val("d_setup_grant", 32'(grant[i]), 32'h1);
                    end
                    2: begin
                        check_val("d_access_pen", 32'(m_penable[i]), 32'd1);
                        check_val("d_access_wdata", m_pwdata[i], 32'hFF);
                    end
                    3: begin
                        check_val("d_s0_ready", 32'(s_pready[i][0]), 32'd1);
                        check_val("d_s1_ready", 32'(s_pready[i][1]), 32'd0);
                        check_val("d_done_psel", 32'(m_psel[i]), 32'd0);
                    end
                    5: begin
                        check_val("d_p1_grant", 32'(grant[i]), 32'h2);
                        check_val("d_p1_paddr", 32'(m_paddr[i]), 32'h50);
                    end
                    7: begin
                        check_val("d_s1_ready", 32'(s_pready[i][1]), 32'd1);
                        check_val("d_s1_rdata", s_prdata[i][1], 32'hA5A5_1234);
                        check_val("d_s0_rdata", s_prdata[i][0], 32'd0);
                    end
                    default: ;
                endcase
            end
        end

        rand_rdata = 1'b1;
        repeat (1500) tick(40);
        repeat (200)  tick(100);

        // pull reset in the middle of an ACCESS cycle of the round-robin instance
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            tick(100);
            if (has_txn[0] && cyc == t0[0] + 2) found = 1'b1;
        end
        check_val("rst_find_access", 32'(found), 32'd1);
        presetn = 1'b0;
        reset_model();
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val("arst_psel", 32'(m_psel[i]), 32'd0);
            check_val("arst_pen", 32'(m_penable[i]), 32'd0);
            check_val("arst_grant", 32'(grant[i]), 32'd0);
            check_val("arst_ready", 32'({s_pready[i][1], s_pready[i][0]}), 32'd0);
        end
        @(posedge clk);
        model_step();
        #1;
        presetn = 1'b1;
        drive_masters(100);
        @(negedge clk);
        check_outputs();
        repeat (300) tick(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
